vending_machine: RTL and testbench

VENDING_MACHINE -- requirements
Module: vending_machine

---
 rtl/vending_machine.sv | 130 +++++++++++++
 tb/tb_vending_machine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// ---------------------------------------------------------------------------
// vending_machine
// Coin-operated chocolate dispenser. One ₹1 coin may arrive per cycle on
// `in`. The FSM accumulates credit (0..2) and dispenses:
//   - a ₹1 chocolate when the coin stream stops at ₹1 credit,
//   - a ₹2 chocolate when it stops at ₹2 credit,
//   - a ₹3 chocolate when a third coin arrives.
// `choco` and `credit` are both registered outputs.
//
// Optional feature macro: VM_SALES_COUNT_EN
//   When defined, the design adds the `sales_total` output. This is a
//   saturating count of rupees dispensed, SALES_W bits wide.
// ---------------------------------------------------------------------------
module vending_machine #(
    parameter int SALES_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    output logic [1:0]         choco,
    output logic [1:0]         credit
`ifdef VM_SALES_COUNT_EN
    ,
    output logic [SALES_W-1:0] sales_total
`endif
);

    // The state encoding doubles as the credit value in rupees; 2'b11 is illegal.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  choco_r;
    logic [1:0]  choco_next_s;

    // Reject out-of-range counter widths at elaboration time.
    if ((SALES_W < 4) || (SALES_W > 32)) begin : g_sales_w_check
        $error("vending_machine: SALES_W must lie in 4..32");
    end

    // Next-state and dispense decision for the coin just sampled.
    always_comb begin
        state_next_s = S0;
        choco_next_s = 2'b00;
        case (state_r)
            S0: begin
                if (in) begin
                    state_next_s = S1;
                end else begin
                    state_next_s = S0;
                end
                choco_next_s = 2'b00;
            end
            S1: begin
                if (in) begin
                    state_next_s = S2;
                    choco_next_s = 2'b00;
                end else begin
                    state_next_s = S0;
                    choco_next_s = 2'b01;
                end
            end
            S2: begin
                // A coin arriving here completes a ₹3 purchase. The coin is
                // consumed by that purchase, so the FSM returns to S0.
                state_next_s = S0;
                if (in) begin
                    choco_next_s = 2'b11;
                end else begin
                    choco_next_s = 2'b10;
                end
            end
            default: begin
                // Illegal encoding: recover quietly, with no dispense.
                state_next_s = S0;
                choco_next_s = 2'b00;
            end
        endcase
    end

    // State and dispense-code registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S0;
            choco_r <= 2'b00;
        end else begin
            state_r <= state_next_s;
            choco_r <= choco_next_s;
        end
    end

    assign choco  = choco_r;
    assign credit = state_r;

`ifdef VM_SALES_COUNT_EN
    logic [SALES_W-1:0] sales_r;

    // Add a 2-bit dispense value to the total, clamping at all-ones.
    function automatic logic [SALES_W-1:0] sat_add(
        input logic [SALES_W-1:0] acc,
        input logic [1:0]         amount
    );
        logic [SALES_W:0] sum;
        sum = {1'b0, acc} + {{(SALES_W - 1){1'b0}}, amount};
        if (sum[SALES_W]) begin
            sat_add = {SALES_W{1'b1}};
        end else begin
            sat_add = sum[SALES_W-1:0];
        end
    endfunction

    // Revenue accumulator: updates on every edge that loads a non-zero code.
    always_ff @(posedge clk) begin
        if (reset) begin
            sales_r <= {SALES_W{1'b0}};
        end else if (choco_next_s != 2'b00) begin
            sales_r <= sat_add(sales_r, choco_next_s);
        end else begin
            sales_r <= sales_r;
        end
    end

    assign sales_total = sales_r;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// ---------------------------------------------------------------------------
// tb_vending_machine
// Directed and random stimulus for vending_machine. Each driven cycle pushes
// the expected {choco, credit, sales} into a scoreboard queue. That entry is
// popped and checked one edge later.
// Revenue checks apply only when VM_SALES_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_vending_machine;

    localparam int TB_SALES_W = 4;
    localparam int SALES_MAX  = (1 << TB_SALES_W) - 1;

    logic       clk;
    logic       reset;
    logic       in;
    logic [1:0] choco;
    logic [1:0] credit;
`ifdef VM_SALES_COUNT_EN
    logic [TB_SALES_W-1:0] sales_total;
`endif

    typedef struct {
        logic [1:0] choco;
        logic [1:0] credit;
        int         sales;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    int n_assert;
    int n_fail;

    // Reference model state.
    int model_credit;
    int model_sales;

    vending_machine #(
        .SALES_W(TB_SALES_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .choco      (choco),
        .credit     (credit)
`ifdef VM_SALES_COUNT_EN
        ,
        .sales_total(sales_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, predict the result, then check it #1 after the edge.
    task automatic step(input logic in_v, input logic rst_v, input string tag);
        exp_t e;
        exp_t got;
        int   disp;
        in    = in_v;
        reset = rst_v;
        disp  = 0;
        if (rst_v) begin
            model_credit = 0;
            model_sales  = 0;
        end else if (in_v) begin
            if (model_credit == 2) begin
                disp         = 3;
                model_credit = 0;
            end else begin
                model_credit = model_credit + 1;
            end
        end else begin
            disp         = model_credit;
            model_credit = 0;
        end
        if (!rst_v) begin
            model_sales = model_sales + disp;
            if (model_sales > SALES_MAX) begin
                model_sales = SALES_MAX;
            end
        end
        e.choco  = 2'(disp);
        e.credit = 2'(model_credit);
        e.sales  = model_sales;
        e.tag    = tag;
        exp_q.push_back(e);

        @(posedge clk);
        #1;

        n_assert++;
        assert (exp_q.size() > 0)
        else begin
            n_fail++;
            $error("FAIL %s_queue: observed empty scoreboard, expected an entry", tag);
        end
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            n_assert++;
            assert (choco === got.choco)
            else begin
                n_fail++;
                $error("FAIL %s_choco: observed %b expected %b", got.tag, choco, got.choco);
            end
            n_assert++;
            assert (credit === got.credit)
            else begin
                n_fail++;
                $error("FAIL %s_credit: observed %0d expected %0d", got.tag, credit, got.credit);
            end
`ifdef VM_SALES_COUNT_EN
            n_assert++;
            assert (32'(sales_total) === got.sales)
            else begin
                n_fail++;
                $error("FAIL %s_sales: observed %0d expected %0d", got.tag, sales_total, got.sales);
            end
`endif
        end
    endtask

    // Directed sequence followed by a random soak.
    initial begin
        n_assert     = 0;
        n_fail       = 0;
        model_credit = 0;
        model_sales  = 0;
        reset        = 1'b1;
        in           = 1'b0;

        // Reset, then idle: nothing is dispensed and credit stays 0.
        step(1'b0, 1'b1, "reset0");
        step(1'b0, 1'b1, "reset1");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");

        // ₹1 purchase.
        step(1'b1, 1'b0, "one_coin");
        step(1'b0, 1'b0, "one_disp");
        step(1'b0, 1'b0, "one_after");

        // ₹2 purchase.
        step(1'b1, 1'b0, "two_c1");
        step(1'b1, 1'b0, "two_c2");
        step(1'b0, 1'b0, "two_disp");
        step(1'b0, 1'b0, "two_after");

        // ₹3 purchase, then a held coin gives another ₹3 three cycles later.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "three_stream");
        step(1'b0, 1'b0, "three_after");

        // Reset mid-purchase discards the credit, then the FSM restarts from S0.
        step(1'b1, 1'b0, "midrst_c1");
        step(1'b1, 1'b0, "midrst_c2");
        step(1'b1, 1'b1, "midrst_rst");
        step(1'b0, 1'b0, "midrst_idle");
        step(1'b1, 1'b0, "post_rst_coin");
        step(1'b0, 1'b0, "post_rst_disp");

        // Repeated ₹3 purchases drive the 4-bit revenue counter into saturation.
        step(1'b0, 1'b1, "sat_reset");
        for (int i = 0; i < 21; i++) step(1'b1, 1'b0, "sat_stream");
        step(1'b0, 1'b0, "sat_idle");

        // Random soak with occasional reset.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0), "random");
        end

        n_assert++;
        assert (exp_q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL drain: observed %0d leftover entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
